// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI command sequencer: FSM state encoding, bus widths
// and the queued command payload.
package spi_seq_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    GAP    = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_cmd_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Command FIFO for the SPI sequencer: pointers with an extra wrap bit, so
// full/empty/level come straight from the registered pointers.
module spi_cmd_fifo
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  spi_cmd_t               din,
  input  logic                   pop,
  output spi_cmd_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  spi_cmd_t      mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues read/write commands and runs them one at a time on the SPI memory top,
// holding it in reset between transactions. SPI_TIMEOUT_EN adds a WAIT watchdog.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_wr,
  output logic [ADDR_W-1:0]      rsp_addr,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   spi_rstn,
  output logic                   spi_wr,
  output logic [ADDR_W-1:0]      spi_addr,
  output logic [DATA_W-1:0]      spi_din,
  input  logic                   spi_done,
  input  logic                   spi_error,
  input  logic [DATA_W-1:0]      spi_dout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_LAUNCH = LAUNCH;
  localparam logic [2:0] S_WAIT   = WAIT;
  localparam logic [2:0] S_RESP   = RESP;
  localparam logic [2:0] S_GAP    = GAP;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       pop;
  logic       done_hit;
  logic       expire;
  logic       accept_en;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  spi_cmd_t   fifo_in;
  spi_cmd_t   head;

  // cmd_ready stays low through reset and rises on the first edge after it.
  assign cmd_ready = accept_en && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign fifo_in   = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};

  spi_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign done_hit = (state == S_WAIT) && spi_done;

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt;

  // Watchdog: completion wins if spi_done lands on the expiry cycle.
  assign expire = (state == S_WAIT) && !spi_done && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      to_cnt <= '0;
    end else if (state == S_WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout_cyc;

  // Without the watchdog WAIT has no exit other than spi_done.
  assign expire             = 1'b0;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // Next-state logic; the only FIFO pop happens on the IDLE -> LAUNCH move.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (done_hit || expire) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_GAP;
      S_GAP:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register plus every registered output, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      accept_en   <= 1'b0;
      busy        <= 1'b0;
      spi_rstn    <= 1'b0;
      spi_wr      <= 1'b0;
      spi_addr    <= '0;
      spi_din     <= '0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_addr    <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      accept_en <= 1'b1;
      busy      <= (state_nxt != S_IDLE);
      spi_rstn  <= (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT);
      rsp_valid <= (state_nxt == S_RESP);

      // The spi_* outputs double as the hold registers for the whole transaction.
      if (pop) begin
        spi_wr   <= head.wr;
        spi_addr <= head.addr;
        spi_din  <= head.data;
      end

      if (done_hit) begin
        rsp_wr      <= spi_wr;
        rsp_addr    <= spi_addr;
        rsp_data    <= spi_wr ? DATA_W'(0) : spi_dout;
        rsp_err     <= spi_error;
        rsp_timeout <= 1'b0;
      end else if (expire) begin
        rsp_wr      <= spi_wr;
        rsp_addr    <= spi_addr;
        rsp_data    <= DATA_W'(0);
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
Command front-end placed directly upstream of the SPI memory top level (master plus slave pair).
- Buffers read/write commands from a valid/ready source in a small FIFO.
- Issues them one at a time on the SPI top's wr/addr/din inputs, holding those inputs stable for the whole transaction.
- Captures done/error/dout and returns one response per command on a valid/ready response port.
- Holds the SPI master in reset between transactions so every transaction starts from a clean state.

Parameters:
DEPTH, 4, command FIFO entries; power of two, at least 2.
TIMEOUT_CYC, 1024, cycles allowed from launch to spi_done before abort (only used with the optional feature).

Ports:
clk  in  1  system clock, all logic rising-edge.
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO not full; a command is accepted when cmd_valid and cmd_ready are both high.
cmd_wr  in  1  1 = write, 0 = read.
cmd_addr  in  8  memory address.
cmd_data  in  8  write data; ignored for reads.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumer ready.
rsp_wr  out  1  echo of the command's wr bit.
rsp_addr  out  8  echo of the command's address.
rsp_data  out  8  read data (captured spi_dout); 0 for writes.
rsp_err  out  1  spi_error was seen, or a timeout occurred.
rsp_timeout  out  1  transaction aborted by the watchdog.
spi_rstn  out  1  active-low reset to the SPI top.
spi_wr  out  1  to the SPI top's wr input.
spi_addr  out  8  to the SPI top's addr input.
spi_din  out  8  to the SPI top's din input.
spi_done  in  1  one-cycle completion pulse from the SPI top.
spi_error  in  1  error flag from the SPI top, sampled with spi_done.
spi_dout  in  8  read data, valid when spi_done is high.
busy  out  1  high whenever the state is not IDLE.
level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
Reset values:
- All outputs are 0 while rst is high, except cmd_ready = 1 once out of reset.
- FIFO empty, FSM in IDLE.
- spi_rstn = 0, so the SPI top is held in reset.

FIFO:
- Write pointer and read pointer, each with an extra wrap bit.
- Full when the indexes are equal and the wrap bits differ; empty when both are equal.
- A push when full is impossible, because cmd_ready = 0.
- A push and a pop in the same cycle are both performed, and level is unchanged.

FSM:
- IDLE: spi_rstn = 0. If the FIFO is not empty, pop the head into the hold registers (wr/addr/data), then go to LAUNCH.
- LAUNCH (1 cycle): spi_wr/spi_addr/spi_din driven from the hold registers; spi_rstn = 1; timeout counter cleared; go to WAIT.
- WAIT: spi_rstn stays 1 and the spi_* outputs stay stable.
  - On spi_done: capture rsp_data = spi_wr ? 0 : spi_dout, rsp_err = spi_error, then go to RESP.
- RESP: rsp_valid = 1. Response fields stay stable until rsp_ready. On the handshake, go to GAP.
- GAP (1 cycle): spi_rstn = 0, then go to IDLE.

Latency and throughput:
- A command pushed into an empty FIFO launches 2 cycles after acceptance: pop in IDLE, then LAUNCH.
- The SPI top therefore sees at least 2 reset-low cycles (GAP plus IDLE) between transactions.

Boundary and corner cases:
- spi_done outside WAIT is ignored.
- rsp_ready low while in RESP stalls the FSM. The FIFO keeps accepting commands until full.
- rst mid-transaction: the FIFO is flushed, the response is dropped, and spi_rstn goes to 0 on the next edge.

Optional Feature:
SPI_TIMEOUT_EN
- Enabled:
  - A counter runs in WAIT.
  - When it reaches TIMEOUT_CYC-1 with no spi_done, go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_data = 0.
  - spi_done in the same cycle as expiry takes priority: normal completion, timeout not flagged.
- Disabled:
  - No counter is present; WAIT waits indefinitely.
  - rsp_timeout is tied to 0.
  - TIMEOUT_CYC is unused.

Decomposition:
Package spi_seq_pkg contains:
- state enum seq_state_e {IDLE, LAUNCH, WAIT, RESP, GAP};
- struct spi_cmd_t {wr, addr[7:0], data[7:0]};
- localparam widths ADDR_W = 8, DATA_W = 8.

Sub-module spi_cmd_fifo:
- Parameterised on DEPTH and storing spi_cmd_t.
- Push/pop interface with full, empty and level outputs.
- The FSM and response registers live in the top.

Test Plan:
1. Write then read: push write (addr 0x10, data 0xA5), then read (addr 0x10); SPI top returns 0xA5 -> responses in order: {wr=1, addr 0x10, data 0, err 0} then {wr=0, addr 0x10, data 0xA5, err 0}; spi_rstn is low for at least 2 cycles between them.
2. Back-to-back fill: push 5 commands with DEPTH=4 while the first is in WAIT -> cmd_ready drops with level = 4; all 5 responses are eventually returned in order.
3. Response backpressure: hold rsp_ready = 0 for 20 cycles in RESP -> rsp fields stay stable and no new spi_rstn=1 occurs; releasing rsp_ready resumes operation.
4. Error propagation: SPI top asserts error with done on a read of addr 0xFF -> rsp_err = 1, rsp_timeout = 0, rsp_addr = 0xFF.
5. Timeout (SPI_TIMEOUT_EN, TIMEOUT_CYC=16): spi_done is never asserted -> rsp_valid appears after 16 WAIT cycles with rsp_err = 1, rsp_timeout = 1; the next command then runs normally.
6. Reset mid-WAIT with 3 queued commands -> next cycle: level = 0, busy = 0, spi_rstn = 0, rsp_valid = 0; no stale response after reset is released.
